// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : Byte-wide UART transmitter. Accepts one byte per valid/ready
//               handshake. Sends a start bit, 8 data bits LSB first, an
//               optional parity bit and 1 or 2 stop bits. Bit timing is
//               CLK_FRE*1e6/BAUD_RATE clocks per bit, which matches the
//               receiver when both are built with the same parameters.
//               Optional feature macro: UART_TX_PARITY_EN adds the parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLK_FRE    = 50,      // clock frequency in MHz
  parameter int BAUD_RATE  = 115200,  // serial baud rate
  parameter int STOP_BITS  = 1,       // 1 or 2; anything else behaves as 1
  parameter int PARITY_ODD = 0        // 0 = even, 1 = odd (parity builds only)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_pin
);

  // Clocks per serial bit, integer division as the receiver computes it.
  localparam int          CYCLE      = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [15:0] CYCLE_LAST = 16'(CYCLE - 1);

  // Value of the 1-bit stop counter during the final stop bit.
  localparam logic        STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;

`ifdef UART_TX_PARITY_EN
  localparam logic        PARITY_SENSE = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
`else
  // Parity sense has no meaning without the parity bit.
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } state_t;

  state_t      state;
  logic [15:0] cycle_cnt;
  logic [2:0]  bit_cnt;
  logic        stop_cnt;
  logic [7:0]  shift;
  logic        cycle_end;

  // Last clock of the current bit period.
  assign cycle_end = (cycle_cnt == CYCLE_LAST);

  // Ready depends on state only, so there is no input-to-output path.
  assign tx_ready = (state == ST_IDLE);

  // Frame sequencer: bit timer, bit/stop counters and the registered line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_pin    <= 1'b1;
      cycle_cnt <= 16'd0;
      bit_cnt   <= 3'd0;
      stop_cnt  <= 1'b0;
      shift     <= 8'd0;
    end else begin
      // Bit timer runs only inside a frame and wraps every bit period.
      if (state == ST_IDLE || cycle_end) begin
        cycle_cnt <= 16'd0;
      end else begin
        cycle_cnt <= cycle_cnt + 16'd1;
      end

      case (state)
        ST_IDLE: begin
          tx_pin   <= 1'b1;
          bit_cnt  <= 3'd0;
          stop_cnt <= 1'b0;
          if (tx_valid && tx_ready) begin
            shift  <= tx_data;
            state  <= ST_START;
            tx_pin <= 1'b0;  // start bit begins on the accept edge
          end
        end

        ST_START: begin
          if (cycle_end) begin
            state   <= ST_DATA;
            tx_pin  <= shift[0];
            bit_cnt <= 3'd0;
          end
        end

        ST_DATA: begin
          if (cycle_end) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state  <= ST_PARITY;
              tx_pin <= (^shift) ^ PARITY_SENSE;
`else
              state    <= ST_STOP;
              tx_pin   <= 1'b1;
              stop_cnt <= 1'b0;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_pin  <= shift[bit_cnt + 3'd1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (cycle_end) begin
            state    <= ST_STOP;
            tx_pin   <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
`endif

        ST_STOP: begin
          tx_pin <= 1'b1;
          if (cycle_end) begin
            if (stop_cnt == STOP_LAST) begin
              state <= ST_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          tx_pin <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
